// File: rtl/types_pkg.sv
// Shared RV32 core types.
//   XLEN / word_t      : datapath width and word type
//   mem_funct3_e       : load/store funct3 encodings (size + sign)
//   dmem_state_e       : data-memory responder FSM states
//   access_illegal()   : funct3/alignment legality check for one access
package types_pkg;

    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } mem_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Returns 1 when funct3 is not legal for the direction or the address
    // is misaligned for the access size. Range checking is done by the caller,
    // which knows the array depth.
    function automatic logic access_illegal(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            LB:      bad = 1'b0;
            LH:      bad = addr_lo[0];
            LW:      bad = (addr_lo != 2'b00);
            LBU:     bad = we;                   // no unsigned stores
            LHU:     bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane selection and extension (combinational).
//   raw     in  XLEN : full word read from the array
//   addr_lo in  2    : byte address bits [1:0]
//   funct3  in  3    : RV32 load funct3
//   data    out XLEN : lane-selected, sign/zero-extended load value
//                      (0 for encodings that are not loads)
module load_extend
    import types_pkg::*;
(
    input  word_t       raw,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output word_t       data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian: byte lane n lives in bits [8n+7:8n].
    assign byte_sel = raw[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        data = '0;
        case (funct3)
            LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LW:      data = raw;
            LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
            LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: far end of the core's load/store port.
// One request at a time over a valid/ready handshake, WAIT_CYCLES wait
// states, RV32 byte/half/word access, response over a second handshake.
//   clk, Reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake
//   req_we, req_addr,
//   req_wdata, req_funct3      : store flag, byte address, store data, size
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata, rsp_err         : extended load data (0 for stores/errors),
//                                illegal-request flag
module dmem_responder
    import types_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  word_t       req_addr,
    input  word_t       req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output word_t       rsp_rdata,
    output logic        rsp_err
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int LANES = XLEN / 8;

    dmem_state_e state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic        we_reg;
    word_t       addr_reg;
    word_t       wdata_reg;
    logic [2:0]  funct3_reg;
    word_t       rdata_reg;
    logic        err_reg;

    word_t       mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        acc_we;
    word_t       acc_addr;
    word_t       acc_wdata;
    logic [2:0]  acc_funct3;
    logic        acc_err;
    word_t       word_idx;
    logic [AW-1:0] mem_idx;
    word_t       rd_word;
    word_t       ld_data;
    logic [LANES-1:0] st_be;
    logic [7:0]  st_lane [LANES];

    // Ready drops as soon as Reset is raised, and is back the cycle it falls.
    assign req_ready = (state_reg == IDLE) && !Reset;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    assign accept = req_valid && req_ready;

    // With zero wait states the access commits on the accept edge, so the
    // live request inputs are used; otherwise the captured copy is used.
    assign acc_we     = (state_reg == IDLE) ? req_we     : we_reg;
    assign acc_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
    assign acc_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
    assign acc_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;

    assign commit = ((state_reg == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                    ((state_reg == WAIT) && (cnt_reg == 4'd0));

    assign word_idx = acc_addr >> 2;
    assign mem_idx  = acc_addr[AW+1:2];
    assign acc_err  = access_illegal(acc_we, acc_funct3, acc_addr[1:0]) ||
                      (word_idx >= word_t'(DEPTH_WORDS));

    assign rd_word = mem[mem_idx];

    load_extend u_load_extend (
        .raw     (rd_word),
        .addr_lo (acc_addr[1:0]),
        .funct3  (acc_funct3),
        .data    (ld_data)
    );

    // Store lane enables and data: sub-word stores replicate the low bits of
    // wdata into the addressed lane(s).
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign st_be[gi] = (acc_funct3[1:0] == 2'd2) ||
                           ((acc_funct3[1:0] == 2'd1) && (acc_addr[1] == LANE[1])) ||
                           ((acc_funct3[1:0] == 2'd0) && (acc_addr[1:0] == LANE));
        assign st_lane[gi] = (acc_funct3[1:0] == 2'd2) ? acc_wdata[gi*8 +: 8] :
                             (acc_funct3[1:0] == 2'd1) ? acc_wdata[(gi%2)*8 +: 8] :
                                                         acc_wdata[7:0];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            funct3_reg <= 3'd0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg     <= req_we;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                funct3_reg <= req_funct3;
            end
            if (commit) begin
                err_reg   <= acc_err;
                rdata_reg <= (!acc_err && !acc_we) ? ld_data : '0;
            end
        end
    end

    // Array write port. Contents survive reset; a store whose commit edge
    // coincides with Reset is dropped.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err && !Reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (st_be[i]) begin
                    mem[mem_idx][i*8 +: 8] <= st_lane[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import types_pkg::*;

    localparam int DEPTH = 64;
    localparam int W_A   = 2;
    localparam int W_B   = 0;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       sel = 1'b0;      // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    word_t      req_addr = '0;
    word_t      req_wdata = '0;
    logic [2:0] req_funct3 = 3'd0;
    logic       rsp_ready = 1'b1;

    logic  req_valid_a, req_valid_b;
    logic  req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
    word_t rsp_rdata_a, rsp_rdata_b;
    logic  req_ready_m, rsp_valid_m, rsp_err_m;
    word_t rsp_rdata_m;

    assign req_valid_a = req_valid & ~sel;
    assign req_valid_b = req_valid & sel;
    assign req_ready_m = sel ? req_ready_b : req_ready_a;
    assign rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
    assign rsp_rdata_m = sel ? rsp_rdata_b : rsp_rdata_a;
    assign rsp_err_m   = sel ? rsp_err_b   : rsp_err_a;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) u_dut_a (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_B)) u_dut_b (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    typedef struct {
        word_t rdata;
        logic  err;
        int    lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request and wait for its accept edge; returns at accept+#1.
    task automatic issue(input logic we, input word_t addr, input word_t wdata,
                         input logic [2:0] f3, input string tag);
        int guard;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        guard = 0;
        while (!req_ready_m && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, " ready"}, 32'(req_ready_m), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Full transaction: push expectation, issue, pop and compare on response,
    // then let one edge pass (the handshake when rsp_ready is high).
    task automatic xact(input logic we, input word_t addr, input word_t wdata,
                        input logic [2:0] f3, input word_t exp_rdata,
                        input logic exp_err, input string tag);
        exp_t e;
        int   lat;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = (sel ? W_B : W_A) + 1;
        sb.push_back(e);
        issue(we, addr, wdata, f3, tag);
        lat = 1;
        while (!rsp_valid_m && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        $display("xact %s sel=%0d we=%0d addr=%h f3=%0d rdata=%h err=%0b lat=%0d",
                 tag, sel, we, addr, f3, rsp_rdata_m, rsp_err_m, lat);
        chk({tag, " lat"},   32'(lat),       32'(e.lat));
        chk({tag, " rdata"}, rsp_rdata_m,    e.rdata);
        chk({tag, " err"},   32'(rsp_err_m), 32'(e.err));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        @(posedge clk); #1;
        chk({tag, " rst req_ready"}, 32'(req_ready_m), 32'd0);
        chk({tag, " rst rsp_valid"}, 32'(rsp_valid_m), 32'd0);
        chk({tag, " rst rdata"},     rsp_rdata_m,      32'd0);
        chk({tag, " rst err"},       32'(rsp_err_m),   32'd0);
        Reset = 1'b0;
        #1;
        chk({tag, " post-rst req_ready"}, 32'(req_ready_m), 32'd1);
        $display("xact %s reset done", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        @(posedge clk); #1;
        do_reset("init");

        xact(1'b1, 32'h10, 32'hDEADBEEF, LW,  32'h0,        1'b0, "SW 10");
        xact(1'b0, 32'h10, 32'h0,        LW,  32'hDEADBEEF, 1'b0, "LW 10");
        xact(1'b0, 32'h13, 32'h0,        LB,  32'hFFFFFFDE, 1'b0, "LB 13");
        xact(1'b0, 32'h13, 32'h0,        LBU, 32'h000000DE, 1'b0, "LBU 13");
        xact(1'b0, 32'h10, 32'h0,        LH,  32'hFFFFBEEF, 1'b0, "LH 10");
        xact(1'b0, 32'h12, 32'h0,        LHU, 32'h0000DEAD, 1'b0, "LHU 12");
        xact(1'b1, 32'h11, 32'h000000AA, LB,  32'h0,        1'b0, "SB 11");
        xact(1'b0, 32'h10, 32'h0,        LW,  32'hDEADAAEF, 1'b0, "LW 10 after SB");
        xact(1'b1, 32'h14, 32'h11223344, LW,  32'h0,        1'b0, "SW 14");
        xact(1'b1, 32'h16, 32'hFFFF5566, LH,  32'h0,        1'b0, "SH 16");
        xact(1'b0, 32'h14, 32'h0,        LW,  32'h55663344, 1'b0, "LW 14");
        xact(1'b0, 32'h15, 32'h0,        LB,  32'h00000033, 1'b0, "LB 15");
        xact(1'b1, 32'h0,  32'h0BADC0DE, LW,  32'h0,        1'b0, "SW 0");

        // Illegal requests: error, no data, no side effect.
        xact(1'b0, 32'h11,        32'h0,        LH,   32'h0, 1'b1, "ERR LH 11");
        xact(1'b1, 32'h12,        32'hCAFEF00D, LW,   32'h0, 1'b1, "ERR SW 12");
        xact(1'b1, 32'(DEPTH*4),  32'hCAFEF00D, LW,   32'h0, 1'b1, "ERR SW oob");
        xact(1'b0, 32'h10,        32'h0,        3'd3, 32'h0, 1'b1, "ERR LD f3=3");
        xact(1'b1, 32'h10,        32'hCAFEF00D, 3'd4, 32'h0, 1'b1, "ERR ST f3=4");
        xact(1'b0, 32'h10, 32'h0, LW, 32'hDEADAAEF, 1'b0, "LW 10 after errs");
        xact(1'b0, 32'h0,  32'h0, LW, 32'h0BADC0DE, 1'b0, "LW 0 after errs");

        // Backpressure: response held for 5 cycles, stray request ignored.
        rsp_ready = 1'b0;
        xact(1'b0, 32'h10, 32'h0, LW, 32'hDEADAAEF, 1'b0, "LW 10 bp");
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
                req_funct3 = LW; req_valid = 1'b1;
            end
            chk("bp rsp_valid", 32'(rsp_valid_m), 32'd1);
            chk("bp rdata",     rsp_rdata_m,      32'hDEADAAEF);
            chk("bp err",       32'(rsp_err_m),   32'd0);
            chk("bp req_ready", 32'(req_ready_m), 32'd0);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp released rsp_valid", 32'(rsp_valid_m), 32'd0);
        $display("xact backpressure hold done");
        xact(1'b0, 32'h0, 32'h0, LW, 32'h0BADC0DE, 1'b0, "LW 0 after bp");

        // Reset during WAIT drops the store.
        xact(1'b1, 32'h20, 32'hA5A5A5A5, LW, 32'h0, 1'b0, "SW 20 prior");
        issue(1'b1, 32'h20, 32'h12345678, LW, "SW 20 aborted");
        do_reset("mid-wait");
        xact(1'b0, 32'h20, 32'h0, LW, 32'hA5A5A5A5, 1'b0, "LW 20 after abort");

        // Reset during RESP keeps the committed store.
        issue(1'b1, 32'h24, 32'h00000077, LW, "SW 24 rsp-reset");
        rsp_ready = 1'b0;
        guard = 0;
        while (!rsp_valid_m && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("SW 24 reached RESP", 32'(rsp_valid_m), 32'd1);
        rsp_ready = 1'b1;
        do_reset("mid-resp");
        xact(1'b0, 32'h24, 32'h0, LW, 32'h00000077, 1'b0, "LW 24 after rsp-reset");

        // Zero-wait-state instance.
        sel = 1'b1;
        #1;
        xact(1'b1, 32'h30, 32'h13579BDF, LW,  32'h0,        1'b0, "W0 SW 30");
        xact(1'b0, 32'h30, 32'h0,        LW,  32'h13579BDF, 1'b0, "W0 LW 30");
        xact(1'b0, 32'h31, 32'h0,        LBU, 32'h0000009B, 1'b0, "W0 LBU 31");
        xact(1'b0, 32'h32, 32'h0,        LH,  32'h00001357, 1'b0, "W0 LH 32");
        xact(1'b0, 32'h33, 32'h0,        LW,  32'h0,        1'b1, "W0 ERR LW 33");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
